fetch_stage: RTL and testbench

Parametrised instruction-fetch stage for the RISC-V pipeline, the successor to the combinational PC+4 / branch-target select. Owns the architectural fetch PC register. Issues pipelined requests to a variable-latency instruction memory and buffers returned instructions with their PCs in an in-order fetch queue feeding decode. Handles branch redirects by flushing the queue and discarding in-flight stale responses.

---
 rtl/fetch_stage_if.sv | 38 +++
 rtl/fetch_stage.sv | 116 +++++++++++
 tb/tb_fetch_stage.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Signal bundle joining the fetch stage to execute (redirect), instruction
// memory (request/response) and decode (instruction hand-off).
interface fetch_stage_if #(
   parameter int unsigned XLEN = 32
);
   // Redirect from execute
   logic            i_b_taken;
   logic [XLEN-1:0] i_b_pc;
   // Instruction memory request / response
   logic            imem_req_valid_out;
   logic [XLEN-1:0] imem_req_addr_out;
   logic            i_imem_req_ready;
   logic            i_imem_rsp_valid;
   logic [31:0]     i_imem_rsp_data;
   // Decode hand-off
   logic            instr_valid_out;
   logic [31:0]     instr_out;
   logic [XLEN-1:0] pc_out;
   logic            i_instr_ready;

   // Fetch stage side
   modport master (
      input  i_b_taken, i_b_pc,
      output imem_req_valid_out, imem_req_addr_out,
      input  i_imem_req_ready, i_imem_rsp_valid, i_imem_rsp_data,
      output instr_valid_out, instr_out, pc_out,
      input  i_instr_ready
   );

   // Environment side (execute, memory, decode)
   modport slave (
      output i_b_taken, i_b_pc,
      input  imem_req_valid_out, imem_req_addr_out,
      output i_imem_req_ready, i_imem_rsp_valid, i_imem_rsp_data,
      input  instr_valid_out, instr_out, pc_out,
      output i_instr_ready
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues pipelined requests to a
// variable-latency instruction memory, and buffers in-order responses with
// their PCs in a small fetch queue feeding decode. A taken branch flushes the
// queue and counts still-in-flight responses so they are discarded on return.
module fetch_stage #(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int unsigned     FQ_DEPTH = 4
) (
   input logic           i_clk,
   input logic           i_rst_n,
   fetch_stage_if.master bus
);
   localparam int unsigned    IDX_W   = $clog2(FQ_DEPTH);
   localparam int unsigned    PTR_W   = IDX_W + 1;
   localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FQ_DEPTH);

   logic [XLEN-1:0]     fetch_pc;
   logic [XLEN-1:0]     slot_pc    [FQ_DEPTH];
   logic [31:0]         slot_instr [FQ_DEPTH];
   logic [FQ_DEPTH-1:0] slot_filled;
   logic [PTR_W-1:0]    alloc_ptr, fill_ptr, head_ptr;
   logic [PTR_W-1:0]    drop_cnt;

   logic [IDX_W-1:0]    alloc_idx, fill_idx, head_idx;
   logic [PTR_W-1:0]    occupancy, unfilled, outstanding, redirect_drop;
   logic [PTR_W:0]      credits_used;
   logic                req_valid, req_fire, head_valid, pop;
   logic                rsp_live, rsp_drop, rsp_fill;
   logic                unused_pc_lsbs;

   assign alloc_idx      = alloc_ptr[IDX_W-1:0];
   assign fill_idx       = fill_ptr[IDX_W-1:0];
   assign head_idx       = head_ptr[IDX_W-1:0];
   // Redirect targets are word aligned; the two low bits are dropped.
   assign unused_pc_lsbs = ^bus.i_b_pc[1:0];

   // Queue bookkeeping and the handshake/response qualifiers for this cycle.
   always_comb begin
      occupancy    = alloc_ptr - head_ptr;
      unfilled     = alloc_ptr - fill_ptr;
      outstanding  = unfilled + drop_cnt;
      credits_used = {1'b0, occupancy} + {1'b0, drop_cnt};
      req_valid    = i_rst_n & ~bus.i_b_taken & (credits_used < DEPTH_C);
      req_fire     = req_valid & bus.i_imem_req_ready;
      head_valid   = slot_filled[head_idx] & (occupancy != '0) & ~bus.i_b_taken;
      pop          = head_valid & bus.i_instr_ready;
      rsp_live     = bus.i_imem_rsp_valid & ~bus.i_b_taken;
      rsp_drop     = rsp_live & (drop_cnt != '0);
      // A response with nothing outstanding is a memory protocol error; ignore it.
      rsp_fill     = rsp_live & (drop_cnt == '0) & (unfilled != '0);
      // Every in-flight response becomes stale; one arriving now is consumed here.
      redirect_drop = (bus.i_imem_rsp_valid && outstanding != '0) ?
                      outstanding - PTR_W'(1) : outstanding;
   end

   // Drive the memory request and the decode-side head view.
   always_comb begin
      // NOTE: defaults first so no path leaves an output unassigned, which would infer a latch.
      bus.instr_valid_out    = 1'b0;
      bus.instr_out          = '0;
      bus.pc_out             = '0;
      bus.imem_req_valid_out = req_valid;
      bus.imem_req_addr_out  = fetch_pc;
      if (head_valid) begin
         bus.instr_valid_out = 1'b1;
         bus.instr_out       = slot_instr[head_idx];
         bus.pc_out          = slot_pc[head_idx];
      end
   end

   // Fetch PC, queue pointers and stale-response counter; redirect wins over all.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      if (!i_rst_n) begin
         fetch_pc  <= RESET_PC;
         alloc_ptr <= '0;
         fill_ptr  <= '0;
         head_ptr  <= '0;
         drop_cnt  <= '0;
      end else if (bus.i_b_taken) begin
         fetch_pc  <= {bus.i_b_pc[XLEN-1:2], 2'b00};
         alloc_ptr <= '0;
         fill_ptr  <= '0;
         head_ptr  <= '0;
         drop_cnt  <= redirect_drop;
      end else begin
         if (req_fire) begin
            alloc_ptr <= alloc_ptr + PTR_W'(1);
            fetch_pc  <= fetch_pc + XLEN'(4);
         end
         if (rsp_drop) drop_cnt <= drop_cnt - PTR_W'(1);
         if (rsp_fill) fill_ptr <= fill_ptr + PTR_W'(1);
         if (pop)      head_ptr <= head_ptr + PTR_W'(1);
      end
   end

   // Per-slot filled flags: cleared on allocation, set when the response lands.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         slot_filled <= '0;
      end else if (bus.i_b_taken) begin
         slot_filled <= '0;
      end else begin
         if (req_fire) slot_filled[alloc_idx] <= 1'b0;
         if (rsp_fill) slot_filled[fill_idx]  <= 1'b1;
      end
   end

   // Slot payload storage.
   // NOTE: the PC/instruction arrays are not reset; the filled flags and pointers guard every read.
   always_ff @(posedge i_clk) begin
      if (req_fire) slot_pc[alloc_idx]   <= fetch_pc;
      if (rsp_fill) slot_instr[fill_idx] <= bus.i_imem_rsp_data;
   end
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a queue-based reference model predicts
// every output each cycle, an in-order memory model answers requests, and a
// few directed scenarios pin exact cycle timing and addresses.
module tb_fetch_stage;
   localparam int unsigned XLEN     = 32;
   localparam logic [31:0] RESET_PC = 32'h0000_0100;
   localparam int unsigned FQ_DEPTH = 4;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      bit          filled;
   } fq_ent_t;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mem_req_t;

   typedef struct {
      int          cyc;
      logic [31:0] a;
      logic [31:0] d;
   } log_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   // Stimulus knobs
   int lat_min, lat_max, req_pct, dec_pct, rsp_pct;

   // Reference model state
   fq_ent_t     fq[$];
   int          m_stale;
   logic [31:0] m_pc;

   // Memory model and observation logs
   mem_req_t mem_q[$];
   log_t     req_log[$];
   log_t     dlv_log[$];

   fetch_stage_if #(.XLEN(XLEN)) bus ();

   fetch_stage #(
      .XLEN     (XLEN),
      .RESET_PC (RESET_PC),
      .FQ_DEPTH (FQ_DEPTH)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] imem_word(input logic [31:0] addr);
      return (addr * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %h, want %h", name, cyc, act, exp);
      end
   endtask

   task automatic set_cfg(input int lmin, input int lmax, input int rq, input int dc, input int rs);
      lat_min = lmin;
      lat_max = lmax;
      req_pct = rq;
      dec_pct = dc;
      rsp_pct = rs;
   endtask

   // One clock cycle of stimulus, applied just after the rising edge.
   task automatic drive_cycle(input bit rst, input bit redir, input logic [31:0] tgt);
      @(posedge clk);
      #1;
      cyc++;
      rst_n                = ~rst;
      bus.i_b_taken        = redir & ~rst;
      bus.i_b_pc           = tgt;
      bus.i_imem_req_ready = ($urandom_range(99) < req_pct);
      bus.i_instr_ready    = ($urandom_range(99) < dec_pct);
      bus.i_imem_rsp_valid = 1'b0;
      bus.i_imem_rsp_data  = $urandom;
      if (rst) begin
         mem_q.delete();
      end else if (mem_q.size() > 0 && mem_q[0].due <= cyc &&
                   $urandom_range(99) < rsp_pct) begin
         bus.i_imem_rsp_valid = 1'b1;
         bus.i_imem_rsp_data  = imem_word(mem_q[0].addr);
         void'(mem_q.pop_front());
      end
   endtask

   task automatic do_reset();
      drive_cycle(1'b1, 1'b0, '0);
      drive_cycle(1'b1, 1'b0, '0);
   endtask

   // Let the current cycle's compare/log step run before inspecting logs.
   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   // Compare process: predict outputs from the model, check, then advance the model.
   always @(negedge clk) begin
      bit          e_req, e_ivalid, placed;
      logic [31:0] e_pc, e_instr;
      int          unfilled;
      if (!rst_n) begin
         fq.delete();
         m_stale = 0;
         m_pc    = RESET_PC;
      end
      unfilled = 0;
      foreach (fq[i]) if (!fq[i].filled) unfilled++;
      e_req    = rst_n && !bus.i_b_taken && (fq.size() + m_stale < FQ_DEPTH);
      e_ivalid = rst_n && !bus.i_b_taken && fq.size() != 0 && fq[0].filled;
      e_pc     = e_ivalid ? fq[0].pc : 32'h0;
      e_instr  = e_ivalid ? fq[0].instr : 32'h0;

      check("req_valid",   bus.imem_req_valid_out, e_req);
      check("req_addr",    bus.imem_req_addr_out,  m_pc);
      check("instr_valid", bus.instr_valid_out,    e_ivalid);
      check("pc_out",      bus.pc_out,             e_pc);
      check("instr_out",   bus.instr_out,          e_instr);

      if (bus.imem_req_valid_out && bus.i_imem_req_ready)
         req_log.push_back('{cyc, bus.imem_req_addr_out, 32'h0});
      if (bus.instr_valid_out && bus.i_instr_ready)
         dlv_log.push_back('{cyc, bus.pc_out, bus.instr_out});

      if (rst_n) begin
         if (bus.i_imem_rsp_valid)
            assert (m_stale + unfilled > 0) else begin
               n_bad++;
               $display("FAIL rsp_protocol @cyc %0d: response with nothing outstanding", cyc);
            end
         if (bus.i_b_taken) begin
            m_stale = m_stale + unfilled - (bus.i_imem_rsp_valid ? 1 : 0);
            if (m_stale < 0) m_stale = 0;
            fq.delete();
            m_pc = bus.i_b_pc & ~32'h3;
         end else begin
            if (bus.i_imem_rsp_valid) begin
               if (m_stale > 0) begin
                  m_stale--;
               end else begin
                  placed = 1'b0;
                  for (int i = 0; i < fq.size(); i++) begin
                     if (!placed && !fq[i].filled) begin
                        fq[i].instr  = bus.i_imem_rsp_data;
                        fq[i].filled = 1'b1;
                        placed       = 1'b1;
                     end
                  end
               end
            end
            if (e_ivalid && bus.i_instr_ready) void'(fq.pop_front());
            if (e_req && bus.i_imem_req_ready) begin
               fq.push_back('{m_pc, 32'h0, 1'b0});
               mem_q.push_back('{m_pc, cyc + $urandom_range(lat_max, lat_min)});
               m_pc = m_pc + 32'h4;
            end
         end
      end
   end

   initial begin
      int rel, r_cyc, pop_cyc;
      rst_n                = 1'b0;
      bus.i_b_taken        = 1'b0;
      bus.i_b_pc           = '0;
      bus.i_imem_req_ready = 1'b0;
      bus.i_imem_rsp_valid = 1'b0;
      bus.i_imem_rsp_data  = '0;
      bus.i_instr_ready    = 1'b0;

      // Latency-1 memory, decode always ready: start-up timing from RESET_PC.
      set_cfg(1, 1, 100, 100, 100);
      do_reset();
      req_log.delete();
      dlv_log.delete();
      drive_cycle(1'b0, 1'b0, '0);
      rel = cyc;
      repeat (7) drive_cycle(1'b0, 1'b0, '0);
      settle();
      check("p1_req_count_ok", req_log.size() >= 3, 1);
      check("p1_dlv_count_ok", dlv_log.size() >= 2, 1);
      if (req_log.size() >= 3 && dlv_log.size() >= 2) begin
         check("p1_req0_cycle", req_log[0].cyc - rel, 0);
         check("p1_req0_addr",  req_log[0].a, 32'h0000_0100);
         check("p1_req2_addr",  req_log[2].a, 32'h0000_0108);
         check("p1_dlv0_cycle", dlv_log[0].cyc - rel, 2);
         check("p1_dlv0_pc",    dlv_log[0].a, 32'h0000_0100);
         check("p1_dlv0_instr", dlv_log[0].d, imem_word(32'h0000_0100));
         check("p1_dlv1_cycle", dlv_log[1].cyc - rel, 3);
         check("p1_dlv1_pc",    dlv_log[1].a, 32'h0000_0104);
      end

      // Redirect during streaming (coincident with a response and a pop) to the top of memory.
      req_log.delete();
      dlv_log.delete();
      drive_cycle(1'b0, 1'b1, 32'hFFFF_FFFE);
      r_cyc = cyc;
      repeat (5) drive_cycle(1'b0, 1'b0, '0);
      settle();
      check("wrap_counts_ok", (req_log.size() >= 2 && dlv_log.size() >= 1), 1);
      if (req_log.size() >= 2 && dlv_log.size() >= 1) begin
         check("wrap_req0_cycle", req_log[0].cyc - r_cyc, 1);
         check("wrap_req0_addr",  req_log[0].a, 32'hFFFF_FFFC);
         check("wrap_req1_addr",  req_log[1].a, 32'h0000_0000);
         check("wrap_dlv0_cycle", dlv_log[0].cyc - r_cyc, 3);
         check("wrap_dlv0_pc",    dlv_log[0].a, 32'hFFFF_FFFC);
      end

      // Decode stalled: exactly FQ_DEPTH requests, then resume one cycle after the first pop.
      set_cfg(1, 1, 100, 0, 100);
      do_reset();
      req_log.delete();
      dlv_log.delete();
      repeat (10) drive_cycle(1'b0, 1'b0, '0);
      settle();
      check("stall_req_count", req_log.size(), 4);
      dec_pct = 100;
      repeat (6) drive_cycle(1'b0, 1'b0, '0);
      settle();
      check("stall_counts_ok", (req_log.size() >= 5 && dlv_log.size() >= 5), 1);
      if (req_log.size() >= 5 && dlv_log.size() >= 5) begin
         pop_cyc = dlv_log[0].cyc;
         check("stall_resume_gap", req_log[4].cyc - pop_cyc, 1);
         for (int i = 0; i < 5; i++)
            check("stall_dlv_pc", dlv_log[i].a, 32'h0000_0100 + 32'(4 * i));
      end

      // Latency-3 memory with 3 requests in flight, redirect to 0x2002.
      set_cfg(3, 3, 100, 100, 100);
      do_reset();
      req_log.delete();
      dlv_log.delete();
      repeat (3) drive_cycle(1'b0, 1'b0, '0);
      drive_cycle(1'b0, 1'b1, 32'h0000_2002);
      r_cyc = cyc;
      repeat (8) drive_cycle(1'b0, 1'b0, '0);
      settle();
      check("l3_counts_ok", (req_log.size() >= 4 && dlv_log.size() >= 1), 1);
      if (req_log.size() >= 4 && dlv_log.size() >= 1) begin
         check("l3_req2_addr",   req_log[2].a, 32'h0000_0108);
         check("l3_req3_addr",   req_log[3].a, 32'h0000_2000);
         check("l3_req3_cycle",  req_log[3].cyc - r_cyc, 1);
         check("l3_dlv0_pc",     dlv_log[0].a, 32'h0000_2000);
         check("l3_dlv0_instr",  dlv_log[0].d, imem_word(32'h0000_2000));
         check("l3_dlv0_cycle",  dlv_log[0].cyc - r_cyc, 5);
      end

      // Randomised traffic: variable latency, back-pressure, redirects and resets.
      for (int round = 0; round < 10; round++) begin
         if (round == 0) set_cfg(1, 2, 100, 100, 100);
         else set_cfg(1, $urandom_range(6, 1), $urandom_range(100, 30),
                      $urandom_range(100, 30), $urandom_range(100, 50));
         if (lat_max < lat_min) lat_max = lat_min;
         for (int c = 0; c < 300; c++) begin
            if ($urandom_range(199) == 0) begin
               do_reset();
            end else if ($urandom_range(99) < 3) begin
               drive_cycle(1'b0, 1'b1,
                           ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                                    : 32'($urandom));
            end else begin
               drive_cycle(1'b0, 1'b0, '0);
            end
         end
      end
      settle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
